// File: rtl/wb_slave_pkg.sv
// Shared types and constants for the Wishbone memory slave.
package wb_slave_pkg;

  // Number of byte lanes on the 32-bit data bus.
  localparam int LANES = 4;

  // Slave transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wbState_e;

  // Termination kind chosen for a captured request.
  typedef enum logic [1:0] {
    ACK = 2'd0,
    ERR = 2'd1,
    RTY = 2'd2
  } respType_e;

endpackage

// File: rtl/wb_slave_mem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port that drives zero whenever no read is being returned.
module wb_slave_mem_array
  import wb_slave_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int MW        = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wrEn_i,
  input  logic [MW-1:0]    wrAddr_i,
  input  logic [31:0]      wrData_i,
  input  logic [LANES-1:0] wrSel_i,
  input  logic             rdEn_i,
  input  logic [MW-1:0]    rdAddr_i,
  output logic [31:0]      rdData_o
);

  logic [31:0] mem_q [MEM_WORDS];
  logic [31:0] rdData_q;

  // Storage is deliberately never reset; only selected byte lanes are updated.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (wrSel_i[i]) begin
          mem_q[wrAddr_i][8*i +: 8] <= wrData_i[8*i +: 8];
        end
      end
    end
  end

  // Read register holds the word only for the cycle after a read, zero otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end else begin
      rdData_q <= '0;
    end
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a word RAM, with programmable wait states,
// address error checking and periodic retry termination.
module wb_slave_mem
  import wb_slave_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 1,
  parameter int RTY_EVERY   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DW-1:0]    data_i,
  output logic [DW-1:0]    data_o,
  input  logic [AW-1:0]    addr_i,
  input  logic [LANES-1:0] sel_i,
  input  logic             we_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  output logic             ack_o,
  output logic             err_o,
  output logic             rty_o
);

  localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = (RTY_EVERY > 0) ? $clog2(RTY_EVERY + 1) : 1;
  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  wbState_e         state_q;
  logic [WW-1:0]    waitCnt_q;
  logic [CW-1:0]    acceptCnt_q;
  logic [MW-1:0]    wordIdx_q;
  logic [DW-1:0]    data_q;
  logic [LANES-1:0] sel_q;
  logic             we_q;
  respType_e        resp_q;
  logic             ack_q;
  logic             err_q;
  logic             rty_q;

  logic             req_d;
  logic             addrErr_d;
  logic [CW-1:0]    acceptNext_d;
  logic             retryDue_d;
  respType_e        captureResp_d;
  logic             enterResp_d;
  respType_e        respNow_d;
  logic             weNow_d;
  logic [MW-1:0]    rdAddr_d;
  logic             rdEn_d;
  logic             wrEn_d;
  logic [DW-1:0]    rdData;

  // Classify the request on the bus and decide which termination it would get.
  always_comb begin
    req_d        = cyc_i & stb_i;
    addrErr_d    = (addr_i[1:0] != 2'b00) ||
                   ({2'b00, addr_i[AW-1:2]} >= AW'(MEM_WORDS));
    acceptNext_d = acceptCnt_q + CW'(1);
    retryDue_d   = (RTY_EVERY > 0) && (acceptNext_d == CW'(RTY_EVERY));
    if (addrErr_d) begin
      captureResp_d = ERR;
    end else if (retryDue_d) begin
      captureResp_d = RTY;
    end else begin
      captureResp_d = ACK;
    end
  end

  // RAM port control: read as the response cycle begins, write as it ends.
  always_comb begin
    enterResp_d = req_d &&
                  (((state_q == IDLE) && (WAIT_STATES == 0)) ||
                   ((state_q == WAIT) && (waitCnt_q == '0)));
    respNow_d   = (state_q == IDLE) ? captureResp_d : resp_q;
    weNow_d     = (state_q == IDLE) ? we_i : we_q;
    rdAddr_d    = (state_q == IDLE) ? addr_i[MW+1:2] : wordIdx_q;
    rdEn_d      = !rst_i && enterResp_d && (respNow_d == ACK) && !weNow_d;
    wrEn_d      = !rst_i && (state_q == RESP) && req_d && (resp_q == ACK) && we_q;
  end

  // Request sequencer: capture, count wait states, drive one registered termination.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      waitCnt_q   <= '0;
      acceptCnt_q <= '0;
      wordIdx_q   <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      resp_q      <= ACK;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rty_q       <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_d) begin
            wordIdx_q <= addr_i[MW+1:2];
            data_q    <= data_i;
            sel_q     <= sel_i;
            we_q      <= we_i;
            resp_q    <= captureResp_d;
            if (!addrErr_d) begin
              acceptCnt_q <= retryDue_d ? '0 : acceptNext_d;
            end
            if (WAIT_STATES == 0) begin
              state_q <= RESP;
              ack_q   <= (captureResp_d == ACK);
              err_q   <= (captureResp_d == ERR);
              rty_q   <= (captureResp_d == RTY);
            end else begin
              state_q   <= WAIT;
              waitCnt_q <= WW'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (!req_d) begin
            state_q <= IDLE;
          end else if (waitCnt_q == '0) begin
            state_q <= RESP;
            ack_q   <= (resp_q == ACK);
            err_q   <= (resp_q == ERR);
            rty_q   <= (resp_q == RTY);
          end else begin
            waitCnt_q <= waitCnt_q - WW'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  wb_slave_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .MW        (MW)
  ) u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wrEn_i   (wrEn_d),
    .wrAddr_i (wordIdx_q),
    .wrData_i (data_q),
    .wrSel_i  (sel_q),
    .rdEn_i   (rdEn_d),
    .rdAddr_i (rdAddr_d),
    .rdData_o (rdData)
  );

  assign data_o = rdData;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign rty_o  = rty_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: directed scenarios plus randomized
// traffic compared against a word-array reference model of the slave.
module tb_wb_slave_mem;

  localparam int W_ST  = 1;
  localparam int R_EV  = 3;
  localparam int WORDS = 256;

  logic        clk = 1'b0;
  logic        rstI;
  logic [31:0] dataI;
  logic [31:0] dataO;
  logic [31:0] addrI;
  logic [3:0]  selI;
  logic        weI;
  logic        cycI;
  logic        stbI;
  logic        ackO;
  logic        errO;
  logic        rtyO;

  int checks   = 0;
  int failures = 0;

  logic [31:0] modelMem   [WORDS];
  bit          modelValid [WORDS];
  int          modelCnt;

  always #5 clk = ~clk;

  wb_slave_mem #(
    .AW          (32),
    .DW          (32),
    .MEM_WORDS   (WORDS),
    .WAIT_STATES (W_ST),
    .RTY_EVERY   (R_EV)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rstI),
    .data_i (dataI),
    .data_o (dataO),
    .addr_i (addrI),
    .sel_i  (selI),
    .we_i   (weI),
    .cyc_i  (cycI),
    .stb_i  (stbI),
    .ack_o  (ackO),
    .err_o  (errO),
    .rty_o  (rtyO)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rule: error for misaligned/out-of-range, else every R_EV-th accept retries.
  task automatic modelAccept(input logic [31:0] addr, output int resp);
    if ((addr[1:0] != 2'b00) || (addr[31:2] >= WORDS)) begin
      resp = 1;
    end else begin
      modelCnt++;
      if (modelCnt == R_EV) begin
        resp     = 2;
        modelCnt = 0;
      end else begin
        resp = 0;
      end
    end
  endtask

  function automatic logic [31:0] flagsOf(input int resp);
    case (resp)
      0:       return 32'h4;
      1:       return 32'h2;
      default: return 32'h1;
    endcase
  endfunction

  // One bus transaction from a negedge; mode 0 normal, 1 abort in wait, 2 reset in wait.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] sel, input int mode,
                               output int obsResp, output logic [31:0] obsData);
    int          expResp;
    logic [31:0] flagsNow;
    int          idx;
    idx = int'(addr[9:2]);
    obsResp = -1;
    obsData = 32'h0;
    modelAccept(addr, expResp);
    cycI  = 1'b1;
    stbI  = 1'b1;
    weI   = we;
    addrI = addr;
    dataI = data;
    selI  = sel;
    @(posedge clk);
    for (int k = 0; k < W_ST; k++) begin
      @(negedge clk);
      checkOutput("waitFlags", {29'b0, ackO, errO, rtyO}, 32'h0);
      checkOutput("waitData", dataO, 32'h0);
      if (k == 0 && mode == 1) begin
        cycI = 1'b0;
        stbI = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abortFlags", {29'b0, ackO, errO, rtyO}, 32'h0);
        return;
      end
      if (k == 0 && mode == 2) begin
        rstI = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midResetFlags", {29'b0, ackO, errO, rtyO}, 32'h0);
        checkOutput("midResetData", dataO, 32'h0);
        rstI = 1'b0;
        cycI = 1'b0;
        stbI = 1'b0;
        modelCnt = 0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    flagsNow = {29'b0, ackO, errO, rtyO};
    obsData  = dataO;
    checkOutput("respFlags", flagsNow, flagsOf(expResp));
    if (!we && expResp == 0) begin
      if (modelValid[idx]) checkOutput("readData", dataO, modelMem[idx]);
    end else begin
      checkOutput("respData", dataO, 32'h0);
    end
    if (ackO) obsResp = 0;
    else if (errO) obsResp = 1;
    else if (rtyO) obsResp = 2;
    @(posedge clk);
    if (we && expResp == 0) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) modelMem[idx][8*i +: 8] = data[8*i +: 8];
      end
      if (sel == 4'hF) modelValid[idx] = 1'b1;
    end
    @(negedge clk);
    cycI = 1'b0;
    stbI = 1'b0;
    checkOutput("idleFlags", {29'b0, ackO, errO, rtyO}, 32'h0);
    checkOutput("idleData", dataO, 32'h0);
  endtask

  // Master behaviour: reissue a request while it is answered with retry (bounded).
  task automatic doTransfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] sel, output logic [31:0] rd);
    int r;
    int tries;
    tries = 0;
    do begin
      applyStimulus(we, addr, data, sel, 0, r, rd);
      tries++;
    end while (r == 2 && tries < 4);
  endtask

  int          rtyPattern [5] = '{0, 0, 2, 0, 0};
  int          obsR;
  logic [31:0] rd;

  initial begin
    rstI  = 1'b1;
    cycI  = 1'b0;
    stbI  = 1'b0;
    weI   = 1'b0;
    addrI = '0;
    dataI = '0;
    selI  = '0;
    modelCnt = 0;
    for (int i = 0; i < WORDS; i++) begin
      modelMem[i]   = 32'h0;
      modelValid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetFlags", {29'b0, ackO, errO, rtyO}, 32'h0);
    checkOutput("resetData", dataO, 32'h0);
    rstI = 1'b0;
    @(negedge clk);

    $display("[TB] retry cadence after reset");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF, 0, obsR, rd);
      checkOutput($sformatf("rtySeq%0d", i), 32'(obsR), 32'(rtyPattern[i]));
    end

    $display("[TB] reset during wait of a write");
    doTransfer(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd);
    applyStimulus(1'b1, 32'h30, 32'h12345678, 4'hF, 2, obsR, rd);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h30, 32'h0, 4'hF, 0, obsR, rd);
      checkOutput($sformatf("postResetRty%0d", i), 32'(obsR), 32'(rtyPattern[i]));
    end
    doTransfer(1'b0, 32'h30, 32'h0, 4'hF, rd);
    checkOutput("noWriteOnReset", rd, 32'hCAFEF00D);

    $display("[TB] full word write and read");
    doTransfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    doTransfer(1'b0, 32'h10, 32'h0, 4'hF, rd);
    checkOutput("deadbeef", rd, 32'hDEADBEEF);

    $display("[TB] byte lanes");
    doTransfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd);
    doTransfer(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd);
    doTransfer(1'b0, 32'h20, 32'h0, 4'hF, rd);
    checkOutput("byteLanes", rd, 32'h11BB33DD);
    doTransfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd);
    doTransfer(1'b0, 32'h20, 32'h0, 4'hF, rd);
    checkOutput("selZeroWrite", rd, 32'h11BB33DD);

    $display("[TB] address errors");
    applyStimulus(1'b0, 32'h400, 32'h0, 4'hF, 0, obsR, rd);
    checkOutput("errRange", 32'(obsR), 32'd1);
    applyStimulus(1'b0, 32'h13, 32'h0, 4'hF, 0, obsR, rd);
    checkOutput("errAlign", 32'(obsR), 32'd1);
    applyStimulus(1'b1, 32'h11, 32'h0, 4'hF, 0, obsR, rd);
    doTransfer(1'b0, 32'h10, 32'h0, 4'hF, rd);
    checkOutput("errNoWrite", rd, 32'hDEADBEEF);

    $display("[TB] abort during wait");
    applyStimulus(1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1, obsR, rd);
    doTransfer(1'b0, 32'h30, 32'h0, 4'hF, rd);
    checkOutput("abortNoWrite", rd, 32'hCAFEF00D);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 16; i++) begin
      doTransfer(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, rd);
    end
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int          pick;
      pick = int'($urandom_range(0, 9));
      if (pick < 8) begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      end else if (pick == 8) begin
        a = 32'h100 + 32'($urandom_range(0, 63)) | 32'h1;
      end else begin
        a = 32'($urandom_range(256, 4095)) << 2;
      end
      doTransfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always ends even if the bench stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=stall expected=finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
